// File: rtl/i2cs_reg.sv
// i2cs_reg: I2C target that bridges master transactions to a byte-wide register bus.
// SCL/SDA are synchronised and deglitched on i_clk; SCL is never stretched.
module i2cs_reg #(
  parameter logic [6:0] SLV_ADDR   = 7'h50,
  parameter int         REG_ADDR_W = 8,
  parameter int         FILT_LEN   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_oe,
  output logic                  o_wr_en,
  output logic [REG_ADDR_W-1:0] o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_rd_en,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]            i_rd_data,
  output logic                  o_busy,
  output logic                  o_stop
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG_PTR,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_LOAD,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  localparam logic [3:0]            FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [REG_ADDR_W-1:0] PTR_ONE  = 1;

  // Line index 0 is SCL, index 1 is SDA.
  logic [1:0] sync_1, sync_2, filt, filt_d;
  logic [3:0] filt_cnt [2];

  logic scl_rise, scl_fall, start_det, stop_det;

  state_t                  state, state_n;
  logic [2:0]              bit_cnt, bit_cnt_n;
  logic [7:0]              shift, shift_n;
  logic [REG_ADDR_W-1:0]   ptr, ptr_n;
  logic                    rw, rw_n;
  logic                    rd_pend;
  logic                    sda_oe_n, busy_n, stop_n;
  logic                    wr_en_n, rd_en_n;
  logic [REG_ADDR_W-1:0]   wr_addr_n, rd_addr_n;
  logic [7:0]              wr_data_n;
  logic [7:0]              rx_byte;

  // A new level is accepted only after FILT_LEN consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_1      <= 2'b11;
      sync_2      <= 2'b11;
      filt        <= 2'b11;
      filt_d      <= 2'b11;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
    end else begin
      sync_1 <= {i_sda, i_scl};
      sync_2 <= sync_1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync_2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_MAX) begin
          filt[i]     <= sync_2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign scl_rise  = filt[0] & ~filt_d[0];
  assign scl_fall  = ~filt[0] & filt_d[0];
  assign start_det = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
  assign stop_det  = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];
  assign rx_byte   = {shift[6:0], filt[1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      rd_pend   <= 1'b0;
      o_sda_oe  <= 1'b0;
      o_busy    <= 1'b0;
      o_stop    <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      rd_pend   <= o_rd_en;
      o_sda_oe  <= sda_oe_n;
      o_busy    <= busy_n;
      o_stop    <= stop_n;
      o_wr_en   <= wr_en_n;
      o_wr_addr <= wr_addr_n;
      o_wr_data <= wr_data_n;
      o_rd_en   <= rd_en_n;
      o_rd_addr <= rd_addr_n;
    end
  end

  // START/STOP override bit handling; ACK slots drive on one fall, release on the next.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    rw_n      = rw;
    sda_oe_n  = o_sda_oe;
    busy_n    = o_busy;
    stop_n    = 1'b0;
    wr_en_n   = 1'b0;
    wr_addr_n = o_wr_addr;
    wr_data_n = o_wr_data;
    rd_en_n   = 1'b0;
    rd_addr_n = o_rd_addr;

    if (rd_pend) shift_n = i_rd_data;

    if (stop_det) begin
      state_n   = S_IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      stop_n    = o_busy;
    end else if (start_det) begin
      state_n   = S_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == SLV_ADDR) begin
                state_n = S_ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = rx_byte[0];
              end else begin
                state_n = S_IGNORE;
                busy_n  = 1'b0;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall && !o_sda_oe) begin
            sda_oe_n = 1'b1;
          end else if (scl_fall && o_sda_oe) begin
            sda_oe_n = 1'b0;
            state_n  = S_REG_PTR;
          end else if (scl_rise && o_sda_oe && rw) begin
            rd_en_n   = 1'b1;
            rd_addr_n = ptr;
            state_n   = S_RD_LOAD;
          end
        end

        S_REG_PTR: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_n   = REG_ADDR_W'(rx_byte);
              state_n = S_WR_ACK;
            end
          end
        end

        S_WR_DATA: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_en_n   = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = rx_byte;
              ptr_n     = ptr + PTR_ONE;
              state_n   = S_WR_ACK;
            end
          end
        end

        S_WR_ACK: begin
          if (scl_fall) begin
            if (!o_sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = S_WR_DATA;
            end
          end
        end

        // The fall that ends an ACK slot puts the first data bit on the bus.
        S_RD_LOAD: begin
          if (scl_fall) begin
            sda_oe_n = ~shift[7];
            shift_n  = {shift[6:0], 1'b0};
            state_n  = S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe_n = 1'b0;
              state_n  = S_RD_ACK;
            end else begin
              sda_oe_n = ~shift[7];
              shift_n  = {shift[6:0], 1'b0};
            end
          end
        end

        S_RD_ACK: begin
          if (scl_rise) begin
            if (!filt[1]) begin
              ptr_n     = ptr + PTR_ONE;
              rd_en_n   = 1'b1;
              rd_addr_n = ptr + PTR_ONE;
              state_n   = S_RD_LOAD;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule
